// File: rtl/debug_bus_arbiter_if.sv
// Debug bus bundle between N masters, the arbiter and one slave.
// Optional error signals exist only when DEBUG_ARB_ERR_EN is defined.
interface debug_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned DATA_WIDTH  = 64
);
    // Master side
    logic [NUM_MASTERS-1:0]            m_req_i;
    logic [NUM_MASTERS-1:0]            m_gnt_o;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]            m_rvalid_o;
    logic [DATA_WIDTH-1:0]             m_rdata_o;
    // Slave side
    logic                              s_req_o;
    logic                              s_gnt_i;
    logic [ADDR_WIDTH-1:0]             s_addr_o;
    logic                              s_we_o;
    logic [DATA_WIDTH-1:0]             s_wdata_o;
    logic                              s_rvalid_i;
    logic [DATA_WIDTH-1:0]             s_rdata_i;
`ifdef DEBUG_ARB_ERR_EN
    logic                              s_err_i;
    logic [NUM_MASTERS-1:0]            m_err_o;
    logic                              err_seen_o;
`endif

    // Arbiter view: it masters the slave port and serves the master ports.
    modport master (
        input  m_req_i, m_addr_i, m_we_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
`ifdef DEBUG_ARB_ERR_EN
        input  s_err_i,
        output m_err_o, err_seen_o,
`endif
        output m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_wdata_o
    );

    // Environment view: debug initiators plus the core's debug slave.
    modport slave (
        output m_req_i, m_addr_i, m_we_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
`ifdef DEBUG_ARB_ERR_EN
        output s_err_i,
        input  m_err_o, err_seen_o,
`endif
        input  m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_wdata_o
    );
endinterface

// File: rtl/debug_bus_arbiter.sv
// N-master to 1-slave debug bus arbiter: round-robin selection, request lock until
// grant, in-order response routing through an ID FIFO.
// Optional error routing and sticky error flag: define DEBUG_ARB_ERR_EN.
module debug_bus_arbiter #(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned ADDR_WIDTH      = 15,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    debug_bus_arbiter_if.master  bus
);
    localparam int unsigned IdW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e               r_state, w_state_next;
    logic [IdW-1:0]       r_sel, w_sel_next;
    logic [IdW-1:0]       r_rr_ptr;
    logic [IdW-1:0]       w_winner, w_cur, w_head;
    logic                 w_found;
    int unsigned          w_idx;
    logic                 r_rst_q;
    logic                 w_blk, w_s_req, w_hs, w_full, w_empty, w_pop;
    logic [IdW-1:0]       r_fifo [MAX_OUTSTANDING];
    logic [PtrW-1:0]      r_wptr, r_rptr;
    logic [CntW-1:0]      r_count;

    // Outputs stay quiet during reset and the cycle right after it.
    assign w_blk   = rst_i | r_rst_q;
    assign w_full  = (r_count == CntW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];
    assign w_pop   = bus.s_rvalid_i && !w_empty && !w_blk;

    // Round-robin winner: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            w_idx = (32'(r_rr_ptr) + i) % NUM_MASTERS;
            if (!w_found && bus.m_req_i[IdW'(w_idx)]) begin
                w_winner = IdW'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    // FSM next-state, current selection and slave request.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cur        = w_winner;
        w_s_req      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cur   = w_winner;
                w_s_req = (|bus.m_req_i) && !w_full && !w_blk;
                if (w_s_req && !bus.s_gnt_i) begin
                    w_state_next = StLocked;
                    w_sel_next   = w_winner;
                end
            end
            StLocked: begin
                w_cur   = r_sel;
                w_s_req = bus.m_req_i[r_sel] && !w_full && !w_blk;
                // A dropped request releases the lock without a handshake.
                if (!bus.m_req_i[r_sel] || (w_s_req && bus.s_gnt_i)) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
        w_hs = w_s_req && bus.s_gnt_i;
    end

    // Slave mux, combinational grant and response routing.
    always_comb begin
        bus.s_req_o    = w_s_req;
        bus.s_addr_o   = '0;
        bus.s_we_o     = 1'b0;
        bus.s_wdata_o  = '0;
        if (w_s_req) begin
            bus.s_addr_o  = bus.m_addr_i[32'(w_cur)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_we_o    = bus.m_we_i[w_cur];
            bus.s_wdata_o = bus.m_wdata_i[32'(w_cur)*DATA_WIDTH +: DATA_WIDTH];
        end
        bus.m_gnt_o    = w_hs ? (NUM_MASTERS'(1) << w_cur) : '0;
        bus.m_rvalid_o = w_pop ? (NUM_MASTERS'(1) << w_head) : '0;
        bus.m_rdata_o  = w_blk ? '0 : bus.s_rdata_i;
    end

    // State, round-robin pointer and ID FIFO.
    always_ff @(posedge clk_i) begin
        r_rst_q <= rst_i;
        if (rst_i) begin
            r_state  <= StIdle;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            if (w_hs) begin
                r_rr_ptr       <= (w_cur == IdW'(NUM_MASTERS - 1)) ? '0 : w_cur + IdW'(1);
                r_fifo[r_wptr] <= w_cur;
                r_wptr <= (r_wptr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + PtrW'(1);
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

`ifdef DEBUG_ARB_ERR_EN
    logic r_err_seen;

    // Error follows the routed response; the sticky flag remembers any routed error.
    always_comb begin
        bus.m_err_o    = (w_pop && bus.s_err_i) ? (NUM_MASTERS'(1) << w_head) : '0;
        bus.err_seen_o = r_err_seen && !w_blk;
    end

    // Sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_seen <= 1'b0;
        end else if (w_pop && bus.s_err_i) begin
            r_err_seen <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Self-checking bench for debug_bus_arbiter: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_debug_bus_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int     mdl_rr = 0;
    int     mdl_lock = -1;
    int     mdl_q[$];
    bit     mdl_prev_rst = 1'b0;
    bit     mdl_err_seen = 1'b0;
    logic [N-1:0] mdl_last_gnt = '0;

    debug_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    debug_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input bit req, input logic [AW-1:0] a, input bit we,
                         input logic [DW-1:0] d);
        bus.m_req_i[k]              = req;
        bus.m_addr_i[k*AW +: AW]    = a;
        bus.m_we_i[k]               = we;
        bus.m_wdata_i[k*DW +: DW]   = d;
    endtask

    task automatic idle_inputs();
        bus.m_req_i    = '0;
        bus.m_addr_i   = '0;
        bus.m_we_i     = '0;
        bus.m_wdata_i  = '0;
        bus.s_gnt_i    = 1'b0;
        bus.s_rvalid_i = 1'b0;
        bus.s_rdata_i  = '0;
`ifdef DEBUG_ARB_ERR_EN
        bus.s_err_i    = 1'b0;
`endif
    endtask

    // One clock: compare all outputs against the model, then advance the model.
    task automatic step();
        logic [N-1:0] req;
        int  sel;
        int  idx;
        bit  blk, full, sreq, hs, pop, gnt;
        logic [N-1:0]  e_gnt, e_rv;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wd;
        #1;
        req  = bus.m_req_i;
        gnt  = bus.s_gnt_i;
        blk  = rst || mdl_prev_rst;
        full = (mdl_q.size() >= MO);
        sel  = -1;
        if (mdl_lock >= 0) begin
            sel  = mdl_lock;
            sreq = req[sel] && !full;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (mdl_rr + k) % N;
                if (sel < 0 && req[idx]) sel = idx;
            end
            sreq = (sel >= 0) && !full;
        end
        sreq   = sreq && !blk;
        hs     = sreq && gnt;
        pop    = !blk && bus.s_rvalid_i && (mdl_q.size() > 0);
        e_gnt  = hs ? (N'(1) << sel) : '0;
        e_rv   = pop ? (N'(1) << mdl_q[0]) : '0;
        e_addr = '0;
        e_we   = 1'b0;
        e_wd   = '0;
        if (sreq) begin
            e_addr = bus.m_addr_i[sel*AW +: AW];
            e_we   = bus.m_we_i[sel];
            e_wd   = bus.m_wdata_i[sel*DW +: DW];
        end
        chk("s_req", 64'(bus.s_req_o), 64'(sreq));
        chk("m_gnt", 64'(bus.m_gnt_o), 64'(e_gnt));
        chk("s_addr", 64'(bus.s_addr_o), 64'(e_addr));
        chk("s_we", 64'(bus.s_we_o), 64'(e_we));
        chk("s_wdata", bus.s_wdata_o, e_wd);
        chk("m_rvalid", 64'(bus.m_rvalid_o), 64'(e_rv));
        chk("m_rdata", bus.m_rdata_o, blk ? 64'd0 : bus.s_rdata_i);
`ifdef DEBUG_ARB_ERR_EN
        chk("m_err", 64'(bus.m_err_o), (pop && bus.s_err_i) ? 64'(e_rv) : 64'd0);
        chk("err_seen", 64'(bus.err_seen_o), 64'(mdl_err_seen && !blk));
`endif
        mdl_last_gnt = e_gnt;
        @(posedge clk);
        if (rst) begin
            mdl_rr = 0;
            mdl_lock = -1;
            mdl_q.delete();
            mdl_err_seen = 1'b0;
        end else begin
            if (pop) begin
`ifdef DEBUG_ARB_ERR_EN
                if (bus.s_err_i) mdl_err_seen = 1'b1;
`endif
                void'(mdl_q.pop_front());
            end
            if (hs) begin
                mdl_q.push_back(sel);
                mdl_rr = (sel + 1) % N;
            end
            if (mdl_lock >= 0) begin
                if (!req[mdl_lock] || hs) mdl_lock = -1;
            end else if (sreq && !gnt) begin
                mdl_lock = sel;
            end
        end
        mdl_prev_rst = rst;
        #1;
    endtask

    initial begin
        logic [N-1:0] rr_gnt [4];
        logic [N-1:0] rr_rv  [4];
        rr_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};

        // Reset: outputs low even with requests pending.
        idle_inputs();
        rst = 1'b1;
        bus.m_req_i = 2'b11;
        bus.s_gnt_i = 1'b1;
        #1 chk("rst_s_req", 64'(bus.s_req_o), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1 chk("post_rst_gnt", 64'(bus.m_gnt_o), 64'd0);
        step();
        idle_inputs();
        step();

        // Single read from m0.
        set_m(0, 1'b1, 15'h0010, 1'b0, '0);
        bus.s_gnt_i = 1'b1;
        #1 chk("rd_gnt", 64'(bus.m_gnt_o), 64'h1);
        chk("rd_addr", 64'(bus.s_addr_o), 64'h10);
        step();
        idle_inputs();
        step();
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 64'hDEADBEEF_00000001;
        #1 chk("rd_rvalid", 64'(bus.m_rvalid_o), 64'h1);
        chk("rd_rdata", bus.m_rdata_o, 64'hDEADBEEF_00000001);
        step();
        idle_inputs();

        // Round robin from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        set_m(0, 1'b1, 15'h0100, 1'b1, 64'h1111);
        set_m(1, 1'b1, 15'h0200, 1'b0, 64'h2222);
        bus.s_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s_rvalid_i = (i > 0);
            bus.s_rdata_i  = 64'(i);
            #1 chk("rr_gnt", 64'(bus.m_gnt_o), 64'(rr_gnt[i]));
            chk("rr_rvalid", 64'(bus.m_rvalid_o), 64'(rr_rv[i]));
            step();
        end
        bus.m_req_i = '0;
        bus.s_gnt_i = 1'b0;
        step();
        idle_inputs();
        step();

        // Lock: m0 held while m1 arrives.
        set_m(0, 1'b1, 15'h0123, 1'b0, '0);
        step();
        set_m(1, 1'b1, 15'h0456, 1'b1, 64'hABCD);
        for (int i = 0; i < 2; i++) begin
            #1 chk("lock_addr", 64'(bus.s_addr_o), 64'h123);
            step();
        end
        bus.s_gnt_i = 1'b1;
        #1 chk("lock_gnt0", 64'(bus.m_gnt_o), 64'h1);
        step();
        bus.m_req_i[0] = 1'b0;
        #1 chk("lock_gnt1", 64'(bus.m_gnt_o), 64'h2);
        step();
        idle_inputs();
        bus.s_rvalid_i = 1'b1;
        step();
        step();
        idle_inputs();

        // Backpressure with a full FIFO.
        set_m(0, 1'b1, 15'h0077, 1'b0, '0);
        bus.s_gnt_i = 1'b1;
        step();
        step();
        #1 chk("bp_full_req", 64'(bus.s_req_o), 64'd0);
        step();
        bus.s_rvalid_i = 1'b1;
        #1 chk("bp_pop_req", 64'(bus.s_req_o), 64'd0);
        step();
        bus.s_rvalid_i = 1'b0;
        #1 chk("bp_resume_req", 64'(bus.s_req_o), 64'd1);
        step();
        idle_inputs();
        bus.s_rvalid_i = 1'b1;
        step();
        step();
        idle_inputs();

        // Reset with two outstanding, then stray responses.
        set_m(0, 1'b1, 15'h0001, 1'b0, '0);
        set_m(1, 1'b1, 15'h0002, 1'b0, '0);
        bus.s_gnt_i = 1'b1;
        step();
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.s_rvalid_i = 1'b1;
        step();
        #1 chk("stray_rvalid", 64'(bus.m_rvalid_o), 64'd0);
        step();
        idle_inputs();
        set_m(1, 1'b1, 15'h0033, 1'b0, '0);
        bus.s_gnt_i = 1'b1;
        #1 chk("post_rst_m1_gnt", 64'(bus.m_gnt_o), 64'h2);
        step();
        idle_inputs();
        bus.s_rvalid_i = 1'b1;
        step();
        idle_inputs();

`ifdef DEBUG_ARB_ERR_EN
        // Error response routed to m1.
        set_m(1, 1'b1, 15'h0044, 1'b0, '0);
        bus.s_gnt_i = 1'b1;
        step();
        idle_inputs();
        bus.s_rvalid_i = 1'b1;
        bus.s_err_i    = 1'b1;
        #1 chk("err_route", 64'(bus.m_err_o), 64'h2);
        step();
        idle_inputs();
        #1 chk("err_sticky", 64'(bus.err_seen_o), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        #1 chk("err_cleared", 64'(bus.err_seen_o), 64'd0);
        step();
`endif

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (bus.m_req_i[k]) begin
                    if (mdl_last_gnt[k]) begin
                        set_m(k, ($urandom % 2) == 0, AW'($urandom), 1'($urandom),
                              {$urandom, $urandom});
                    end else if ($urandom % 60 == 0) begin
                        bus.m_req_i[k] = 1'b0;
                    end
                end else if ($urandom % 5 < 2) begin
                    set_m(k, 1'b1, AW'($urandom), 1'($urandom), {$urandom, $urandom});
                end
            end
            bus.s_gnt_i    = ($urandom % 3) != 0;
            bus.s_rvalid_i = (mdl_q.size() > 0) ? 1'($urandom) : ($urandom % 10 == 0);
            bus.s_rdata_i  = {$urandom, $urandom};
`ifdef DEBUG_ARB_ERR_EN
            bus.s_err_i    = ($urandom % 4) == 0;
`endif
            rst = ($urandom % 250) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_bus_arbiter.md
Name: debug_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the memory-mapped debug bus (req/gnt/rvalid protocol).
- Successor to the single-channel debug interface: parametrised master count, address width and data width, plus support for multiple outstanding transactions.
- Sits between debug initiators (debug module, JTAG bridge, trace unit) and the core's debug slave.
- Uses round-robin arbitration, a request lock until grant, and in-order response routing through an ID FIFO.

Parameters:
- NUM_MASTERS, 2, number of master ports (>=1).
- ADDR_WIDTH, 15, debug address width.
- DATA_WIDTH, 64, read/write data width.
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO (>=1).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- m_req_i  input  NUM_MASTERS  per-master request.
- m_gnt_o  output  NUM_MASTERS  per-master grant.
- m_addr_i  input  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k occupies slice k.
- m_we_i  input  NUM_MASTERS  per-master write enable.
- m_wdata_i  input  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_rvalid_o  output  NUM_MASTERS  per-master response valid.
- m_rdata_o  output  DATA_WIDTH  read data, broadcast to all masters.
- s_req_o  output  1  slave request.
- s_gnt_i  input  1  slave grant.
- s_addr_o  output  ADDR_WIDTH  slave address.
- s_we_o  output  1  slave write enable.
- s_wdata_o  output  DATA_WIDTH  slave write data.
- s_rvalid_i  input  1  slave response valid.
- s_rdata_i  input  DATA_WIDTH  slave read data.

Behaviour:
- Protocol:
  - A master holds req/addr/we/wdata stable until gnt.
  - The address phase completes on the req&&gnt cycle.
  - Every accepted transaction, read or write, returns exactly one rvalid one or more cycles later.
  - Responses return in order.
- Reset: while rst_i is high, and on the cycle after:
  - rr_ptr=0, FIFO empty, lock clear.
  - All outputs are forced low: s_req_o, m_gnt_o, m_rvalid_o; s_addr_o/s_we_o/s_wdata_o/m_rdata_o=0.
  - Responses outstanding at reset are lost; any s_rvalid_i arriving later with an empty FIFO is dropped.
- State machine, two states:
  - IDLE: the winner is the first requester at or after rr_ptr, wrapping modulo NUM_MASTERS. s_req_o=|m_req_i && !fifo_full. If s_req_o && !s_gnt_i: latch sel=winner and go to LOCKED. If s_gnt_i: handshake, stay in IDLE.
  - LOCKED: sel is held, and the slave sees sel's request fields. s_req_o=m_req_i[sel] && !fifo_full. On s_gnt_i: handshake, go to IDLE. If m_req_i[sel] drops (protocol violation): go to IDLE, with no handshake that cycle.
- Mux: s_addr_o/s_we_o/s_wdata_o take the slice of the current selection (winner in IDLE, sel in LOCKED). When s_req_o=0 they are 0.
- Grant: m_gnt_o[k]=s_req_o && s_gnt_i && (selection==k). This is combinational and at most one-hot.
- Round-robin update: on handshake, rr_ptr <= (selection+1) mod NUM_MASTERS.
- ID FIFO:
  - Width max(1,$clog2(NUM_MASTERS)).
  - Push the selection index on handshake; pop on s_rvalid_i && !empty.
  - fifo_full blocks new requests even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, pointers both advance and wrap at MAX_OUTSTANDING.
- Response:
  - m_rvalid_o[head]=s_rvalid_i && !empty, with zero added latency; m_rdata_o=s_rdata_i.
  - An s_rvalid_i arriving with an empty FIFO is ignored.
- A response may arrive in the same cycle as its own grant only if the slave supports it. That case is handled: push happens before pop visibility, so an rvalid while the FIFO is empty is dropped; slaves must respond at least one cycle after grant.

Optional Feature:
- Macro DEBUG_ARB_ERR_EN adds:
  - Input s_err_i (1).
  - Output m_err_o (NUM_MASTERS).
  - m_err_o[head]=s_err_i && s_rvalid_i && !empty; it is 0 during reset.
  - A one-bit sticky register err_seen, set on any routed error and cleared by reset, exported as err_seen_o (1).
- Without the macro: these ports do not exist; behaviour is otherwise identical.

Test Plan:
- Single read: m0 req addr=0x0010, slave gnt same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF_00000001 -> m_gnt_o=01 in cycle 0; m_rvalid_o=01 with that rdata in cycle 2; m1 sees no rvalid.
- Round-robin: m0 and m1 both request continuously, slave always grants -> grants alternate 01,10,01,10; responses route to the matching master in order.
- Lock: m0 requests, slave withholds gnt for 3 cycles while m1 raises req in cycle 1 -> s_addr_o stays at m0's address; m0 is granted in cycle 3; m1 is granted next.
- Backpressure: MAX_OUTSTANDING=2, two grants with no rvalid -> s_req_o=0 while m_req_i is pending; after one rvalid, s_req_o rises the following cycle.
- Reset mid-operation: 2 outstanding, rst_i pulsed for 1 cycle, then 2 stray s_rvalid_i arrive -> no m_rvalid_o; rr_ptr=0; the next request from m1 is granted normally.
- DEBUG_ARB_ERR_EN: response with s_err_i=1 to m1 -> m_err_o=10 in the same cycle as rvalid; err_seen_o=1 until reset.
